// File: rtl/fpga_sram_pkg.sv
// fpga_sram_pkg: shared state type, default tile size and tile-index width helper
// for the tiled block-RAM bank.
package fpga_sram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } bank_state_e;

    localparam int DefaultTileWords = 8192;

    // Width of the tile-index field; at least one bit so a single-tile bank still elaborates.
    function automatic int tile_idx_width(input int num_tiles);
        return (num_tiles > 1) ? $clog2(num_tiles) : 1;
    endfunction

endpackage

// File: rtl/fpga_sram_tile.sv
// fpga_sram_tile: one inferable single-port block-RAM tile with per-byte write
// enables and a read-first registered output.
module fpga_sram_tile #(
    parameter int Words     = 8192,
    parameter int DataWidth = 32,
    localparam int AW       = $clog2(Words),
    localparam int BW       = DataWidth / 8
) (
    input  logic                 clka,
    input  logic                 ena,
    input  logic [BW-1:0]        wea,
    input  logic [AW-1:0]        addra,
    input  logic [DataWidth-1:0] dina,
    output logic [DataWidth-1:0] douta
);

    logic [DataWidth-1:0] r_mem [Words];
    logic [DataWidth-1:0] r_douta;

    // Read-first port: the output captures the old word while enabled bytes are updated.
    always_ff @(posedge clka) begin
        if (ena) begin
            r_douta <= r_mem[addra];
            for (int b = 0; b < BW; b++) begin
                if (wea[b]) begin
                    r_mem[addra][b*8 +: 8] <= dina[b*8 +: 8];
                end
            end
        end
    end

    assign douta = r_douta;

endmodule

// File: rtl/fpga_sram_bank.sv
// fpga_sram_bank: block-RAM tiles stacked to NumWords x DataWidth behind a
// combinational request/grant handshake with a registered read-valid.
// Defining FPGA_SRAM_INIT_CLEAR_EN adds a post-reset sequencer that zeroes all
// tiles in parallel before traffic is accepted.
module fpga_sram_bank
    import fpga_sram_pkg::*;
#(
    parameter int NumWords  = 32768,
    parameter int DataWidth = 32,
    parameter int TileWords = DefaultTileWords,
    parameter int NumTiles  = NumWords / TileWords,
    parameter int AddrWidth = $clog2(NumWords),
    parameter int BeWidth   = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    input  logic [NumTiles-1:0]  set_retentive_ni,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 init_done_o
);

    localparam int TileAw   = $clog2(TileWords);
    localparam int TileIdxW = tile_idx_width(NumTiles);
    // Tile slots padded to a power of two; slots past NumTiles are the out-of-range region.
    localparam int NumSlots = 2 ** TileIdxW;

    if (NumWords % TileWords != 0) begin : g_chk_words
        $error("fpga_sram_bank: NumWords must be a multiple of TileWords");
    end
    if (DataWidth % 8 != 0) begin : g_chk_width
        $error("fpga_sram_bank: DataWidth must be a multiple of 8");
    end
    if ((TileWords & (TileWords - 1)) != 0) begin : g_chk_pow2
        $error("fpga_sram_bank: TileWords must be a power of two");
    end

    logic [TileIdxW-1:0]  w_tile;
    logic [TileAw-1:0]    w_local;
    logic [NumSlots-1:0]  w_slot_ok;
    logic [DataWidth-1:0] w_douta [NumSlots];
    logic                 w_clr;
    logic [TileAw-1:0]    w_clr_addr;
    logic                 w_gnt;
    logic [DataWidth-1:0] w_rdata;
    bank_state_e          r_state;
    bank_state_e          w_state_next;
    logic                 r_rvalid;
    logic                 r_rd_pend;
    logic [TileIdxW-1:0]  r_rd_sel;
    logic [DataWidth-1:0] r_rdata_hold;

    assign w_local = addr_i[TileAw-1:0];
    if (NumTiles > 1) begin : g_tsel
        assign w_tile = addr_i[AddrWidth-1:TileAw];
    end else begin : g_tsel_single
        assign w_tile = '0;
    end

`ifdef FPGA_SRAM_INIT_CLEAR_EN
    logic [TileAw-1:0] r_clr_cnt;

    // State register and clear address counter; reset always restarts the clear at word 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == INIT) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // Leave INIT once the last local word of every tile has been written.
    always_comb begin
        w_state_next = r_state;
        if (r_state == INIT && r_clr_cnt == TileAw'(TileWords - 1)) begin
            w_state_next = READY;
        end
    end

    assign w_clr       = (r_state == INIT);
    assign w_clr_addr  = r_clr_cnt;
    assign init_done_o = (r_state == READY);
`else
    // State register; without the clear sequencer the bank is ready straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= READY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Nothing to sequence: stay in READY.
    always_comb begin
        w_state_next = READY;
    end

    assign w_clr       = 1'b0;
    assign w_clr_addr  = '0;
    assign init_done_o = 1'b1;
`endif

    // Retentive tiles refuse access; out-of-range slots always grant so the bus never stalls.
    assign w_gnt = req_i & (r_state == READY) & w_slot_ok[w_tile];
    assign gnt_o = w_gnt;

    for (genvar t = 0; t < NumSlots; t++) begin : g_tile
        if (t < NumTiles) begin : g_real
            localparam logic [TileIdxW-1:0] Idx = TileIdxW'(t);
            logic                 w_ena;
            logic [BeWidth-1:0]   w_wea;
            logic [TileAw-1:0]    w_addra;
            logic [DataWidth-1:0] w_dina;

            // The clear drives every tile at once, overriding the retention inputs.
            assign w_ena        = w_clr | (w_gnt & (w_tile == Idx));
            assign w_wea        = w_clr ? '1 : (we_i ? be_i : '0);
            assign w_addra      = w_clr ? w_clr_addr : w_local;
            assign w_dina       = w_clr ? '0 : wdata_i;
            assign w_slot_ok[t] = set_retentive_ni[t];

            fpga_sram_tile #(
                .Words     (TileWords),
                .DataWidth (DataWidth)
            ) u_tile (
                .clka  (clk_i),
                .ena   (w_ena),
                .wea   (w_wea),
                .addra (w_addra),
                .dina  (w_dina),
                .douta (w_douta[t])
            );
        end else begin : g_empty
            assign w_slot_ok[t] = 1'b1;
            assign w_douta[t]   = '0;
        end
    end

    // Fresh tile output only in the cycle after a granted read; otherwise hold the last value.
    assign w_rdata = r_rd_pend ? w_douta[r_rd_sel] : r_rdata_hold;

    // Response tracking: valid for every grant, plus the read-select and held read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid     <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rd_sel     <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_rvalid     <= w_gnt;
            r_rd_pend    <= w_gnt & ~we_i;
            r_rd_sel     <= w_tile;
            r_rdata_hold <= w_rdata;
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = w_rdata;

endmodule

// File: tb/tb_fpga_sram_bank.sv
// tb_fpga_sram_bank: randomized and directed traffic against a word-level memory
// model; a monitor matches every response against a queue of expected results.
module tb_fpga_sram_bank;

    localparam int AW = 15;
    localparam int NT = 4;
    localparam int TW = 8192;
`ifdef FPGA_SRAM_INIT_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req, we, gnt, rvalid, init_done;
    logic [AW-1:0] addr;
    logic [31:0]   wdata, rdata;
    logic [3:0]    be, ret;

    logic          req2, we2, gnt2, rvalid2, init_done2;
    logic [14:0]   addr2;
    logic [31:0]   wdata2, rdata2;
    logic [3:0]    be2;
    logic [2:0]    ret2;

    fpga_sram_bank #(.NumWords(32768)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .set_retentive_ni(ret),
        .rvalid_o(rvalid), .rdata_o(rdata), .init_done_o(init_done)
    );

    fpga_sram_bank #(.NumWords(24576)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .gnt_o(gnt2), .we_i(we2),
        .addr_i(addr2), .wdata_i(wdata2), .be_i(be2), .set_retentive_ni(ret2),
        .rvalid_o(rvalid2), .rdata_o(rdata2), .init_done_o(init_done2)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: word store with per-byte knowledge, last read result, ready flag.
    logic [31:0] mem  [int];
    logic [3:0]  mmask[int];
    bit          model_ready;
    logic [31:0] last_data;
    logic [3:0]  last_mask;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [3:0]  mask;
    } exp_t;
    exp_t sbq[$];

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic model_word(input int a, output logic [31:0] d, output logic [3:0] m);
        if (mem.exists(a)) begin
            d = mem[a];
            m = mmask[a];
        end else begin
            d = 32'h0;
            m = CLEAR ? 4'hF : 4'h0;
        end
    endtask

    task automatic model_reset();
        mem.delete();
        mmask.delete();
        last_data   = 32'h0;
        last_mask   = 4'hF;
        model_ready = 1'b0;
    endtask

    // Monitor: any cycle with a response due must show rvalid and the expected bytes.
    initial begin
        exp_t e;
        logic [31:0] m32;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    e   = sbq.pop_front();
                    m32 = byte_mask(e.mask);
                    chk("rvalid", 32'(rvalid), 32'd1);
                    chk("rdata", rdata & m32, e.data & m32);
                end else begin
                    chk("rvalid_idle", 32'(rvalid), 32'd0);
                end
            end
        end
    end

    task automatic idle();
        req = 1'b0;
        we  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drive one request for a cycle; called just after a rising edge.
    task automatic access(input bit w, input int a, input logic [31:0] d, input logic [3:0] b);
        exp_t        e;
        bit          eg;
        int          t;
        logic [31:0] old;
        logic [3:0]  om;
        req   = 1'b1;
        we    = w;
        addr  = AW'(a);
        wdata = d;
        be    = b;
        @(negedge clk);
        t  = a / TW;
        eg = model_ready && ((t < NT) ? ret[t] : 1'b1);
        chk("gnt", 32'(gnt), 32'(eg));
        if (eg) begin
            e.due = cyc + 1;
            model_word(a, old, om);
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) begin
                        old[i*8 +: 8] = d[i*8 +: 8];
                        om[i]         = 1'b1;
                    end
                end
                mem[a]   = old;
                mmask[a] = om;
                e.data   = last_data;
                e.mask   = last_mask;
            end else begin
                last_data = old;
                last_mask = om;
                e.data    = old;
                e.mask    = om;
            end
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
    endtask

    // Count rising edges until init_done; called at a falling edge.
    task automatic wait_init(input string name);
        int n = 0;
        while (init_done !== 1'b1 && n < 20000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk(name, 32'(n), CLEAR ? 32'(TW) : 32'd0);
        model_ready = 1'b1;
    endtask

    // Single access to the three-tile bank with direct response checks.
    task automatic acc2(input bit w, input int a, input logic [31:0] d, input bit rd_chk,
                        input logic [31:0] exp_rd);
        req2   = 1'b1;
        we2    = w;
        addr2  = 15'(a);
        wdata2 = d;
        be2    = 4'hF;
        @(negedge clk);
        chk("gnt2", 32'(gnt2), 32'd1);
        @(posedge clk);
        #1;
        req2 = 1'b0;
        we2  = 1'b0;
        @(negedge clk);
        chk("rvalid2", 32'(rvalid2), 32'd1);
        if (rd_chk) chk("rdata2", rdata2, exp_rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; ret = 4'hF;
        req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0; be2 = '0; ret2 = 3'h7;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_init_done", 32'(init_done), 32'(!CLEAR));
        rst_n = 1'b1;
        wait_init("init_len");
        @(posedge clk);
        #1;

        // Cleared contents at the ends of the address range.
        access(0, 0, 32'h0, 4'h0);
        access(0, 8191, 32'h0, 4'h0);
        access(0, 32767, 32'h0, 4'h0);

        // Byte-enable merge over a full write.
        access(1, 32'h2005, 32'hFFFF_FFFF, 4'hF);
        access(1, 32'h2005, 32'hDEAD_BEEF, 4'b0101);
        access(0, 32'h2005, 32'h0, 4'h0);
        idle();

        // Tagged words then back-to-back reads across all tiles.
        for (int i = 0; i < 4; i++) access(1, i * TW, 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) access(0, i * TW, 32'h0, 4'h0);
        idle();

        // Retention on tile 1 blocks reads and writes; data survives.
        access(1, 32'h2010, 32'hA5A5_1234, 4'hF);
        ret = 4'b1101;
        access(0, 32'h2010, 32'h0, 4'h0);
        access(1, 32'h2010, 32'h0, 4'hF);
        ret = 4'hF;
        access(0, 32'h2010, 32'h0, 4'h0);
        idle();

        // Randomized traffic with occasional retention changes in the request cycle.
        for (int i = 0; i < 400; i++) begin
            ret = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 4) == 0) begin
                idle();
            end else begin
                a = $urandom_range(0, 3) * TW + $urandom_range(0, 15);
                access(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
            end
        end
        ret = 4'hF;
        repeat (3) idle();

        // Out-of-range region of a three-tile bank: granted, writes dropped, reads zero.
        acc2(1, 5, 32'h0000_1234, 1'b0, 32'h0);
        acc2(0, 5, 32'h0, 1'b1, 32'h0000_1234);
        acc2(1, 32'h6000, 32'hFFFF_FFFF, 1'b0, 32'h0);
        acc2(0, 32'h6000, 32'h0, 1'b1, 32'h0);

        // Reset pulse 100 cycles into the clear restarts it from the beginning.
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("pulse_rdata", rdata, 32'h0);
        chk("pulse_init_done", 32'(init_done), 32'(!CLEAR));
        rst_n = 1'b1;
        wait_init("reinit_len");
        @(posedge clk);
        #1;
        access(0, 32'h2005, 32'h0, 4'h0);
        access(0, 32'h0, 32'h0, 4'h0);
        repeat (3) idle();

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
